// File: rtl/mul_seq_ctrl.sv
// Sequencing controller for the iterative shift-add multiplier behind the R-type mul (ALU code 4'b1010).
// Optional feature macro: MUL_SIGNED_EN (two's complement operands via magnitude latch and final negation).
module mul_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] result_hi_o,
    output logic             done_o,
    output logic             busy_o,
    output logic             stall_o
);

    localparam logic [3:0]    ALU_MUL  = 4'b1010;
    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_res_lo;
    logic [WIDTH-1:0]     r_res_hi;
    logic                 r_done;
    logic                 r_busy;
`ifdef MUL_SIGNED_EN
    logic                 r_neg;

    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] f_neg(input logic [2*WIDTH-1:0] v);
        return ~v + (2*WIDTH)'(1);
    endfunction
`endif

    logic                 w_accept;
    logic [WIDTH-1:0]     w_addend;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [WIDTH-1:0]     w_mplier_next;
    logic [2*WIDTH-1:0]   w_product;
    logic [WIDTH-1:0]     w_mcand_in;
    logic [WIDTH-1:0]     w_mplier_in;

    // Accept decode and one shift-add step: the carry of the upper-half add shifts down with the accumulator.
    always_comb begin
        w_accept      = start_i && (ALUCtrl_i == ALU_MUL) &&
                        ((r_state == ST_IDLE) || (r_state == ST_DONE));
        w_addend      = r_mplier[0] ? r_mcand : {WIDTH{1'b0}};
        w_sum         = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
        w_acc_next    = {w_sum, r_acc[WIDTH-1:1]};
        w_mplier_next = {r_acc[0], r_mplier[WIDTH-1:1]};
`ifdef MUL_SIGNED_EN
        w_mcand_in    = f_mag(src1_i);
        w_mplier_in   = f_mag(src2_i);
        w_product     = r_neg ? f_neg(w_acc_next) : w_acc_next;
`else
        w_mcand_in    = src1_i;
        w_mplier_in   = src2_i;
        w_product     = w_acc_next;
`endif
    end

    // The pipeline must freeze in the accept cycle itself, so stall cannot wait for the state register.
    assign stall_o     = w_accept || (r_state == ST_RUN);
    assign done_o      = r_done;
    assign busy_o      = r_busy;
    assign result_o    = r_res_lo;
    assign result_hi_o = r_res_hi;

    // Sequencer FSM with datapath registers and registered state decodes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_mcand  <= {WIDTH{1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_acc    <= {(2*WIDTH){1'b0}};
            r_cnt    <= {CW{1'b0}};
            r_res_lo <= {WIDTH{1'b0}};
            r_res_hi <= {WIDTH{1'b0}};
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
`ifdef MUL_SIGNED_EN
            r_neg    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_mcand  <= w_mcand_in;
                        r_mplier <= w_mplier_in;
                        r_acc    <= {(2*WIDTH){1'b0}};
                        r_cnt    <= CNT_LOAD;
`ifdef MUL_SIGNED_EN
                        r_neg    <= src1_i[WIDTH-1] ^ src2_i[WIDTH-1];
`endif
                        r_state  <= ST_RUN;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                    end else begin
                        r_state  <= ST_IDLE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_acc    <= w_acc_next;
                    r_mplier <= w_mplier_next;
                    r_cnt    <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_state  <= ST_DONE;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_res_hi <= w_product[2*WIDTH-1:WIDTH];
                        r_res_lo <= w_product[WIDTH-1:0];
                    end else begin
                        r_state  <= ST_RUN;
                        r_done   <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: an arithmetic reference model compared every cycle, plus literal checks.
module tb_mul_seq_ctrl;

    localparam int         W   = 32;
    localparam logic [3:0] MUL = 4'b1010;

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    ctrl  = 4'd0;
    logic [W-1:0]  src1  = '0;
    logic [W-1:0]  src2  = '0;
    logic [W-1:0]  result_lo;
    logic [W-1:0]  result_hi;
    logic          done;
    logic          busy;
    logic          stall;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: cycles of RUN left, expected done pulse, published and pending products.
    int              m_left = 0;
    logic            m_done = 1'b0;
    logic [2*W-1:0]  m_res  = '0;
    logic [2*W-1:0]  m_pend = '0;

    mul_seq_ctrl #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .ALUCtrl_i   (ctrl),
        .src1_i      (src1),
        .src2_i      (src2),
        .result_o    (result_lo),
        .result_hi_o (result_hi),
        .done_o      (done),
        .busy_o      (busy),
        .stall_o     (stall)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MUL_SIGNED_EN
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
`else
        return {32'd0, a} * {32'd0, b};
`endif
    endfunction

    // Model advance: a product appears WIDTH edges after acceptance; requests during a run are dropped.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_res  <= '0;
            m_pend <= '0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_res  <= m_pend;
            end else begin
                m_done <= 1'b0;
            end
        end else begin
            m_done <= 1'b0;
            if (start && ctrl == MUL) begin
                m_left <= W;
                m_pend <= prod(src1, src2);
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        logic exp_stall;
        exp_stall = (m_left > 0) || (start && ctrl == MUL && m_left == 0);
        check("model_stall", 64'(stall), 64'(exp_stall));
        check("model_busy",  64'(busy),  64'(m_left > 0));
        check("model_done",  64'(done),  64'(m_done));
        check("model_lo",    64'(result_lo), 64'(m_res[W-1:0]));
        check("model_hi",    64'(result_hi), 64'(m_res[2*W-1:W]));
    endtask

    task automatic sample();
        @(negedge clk);
        cmp_model();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Accepts a*b in the current cycle and returns at the negedge of the done cycle with its cycle number.
    task automatic mul_wait(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        start = 1'b1; ctrl = MUL; src1 = a; src2 = b;
        sample();
        check("accept_stall", 64'(stall), 64'd1);
        adv();
        start = 1'b0;
        lat = 1;
        sample();
        while (!done && lat < 100) begin
            adv();
            lat++;
            sample();
        end
    endtask

    initial begin
        int lat;
        int c;
        int extra;

        #1 rst = 1'b1;
        sample();
        check("rst_lo",    64'(result_lo), 64'd0);
        check("rst_hi",    64'(result_hi), 64'd0);
        check("rst_done",  64'(done),  64'd0);
        check("rst_busy",  64'(busy),  64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        adv();
        rst = 1'b0;
        sample();
        adv();

        // Basic 3*5.
        mul_wait(32'd3, 32'd5, lat);
        check("basic_latency", 64'(lat), 64'd33);
        check("basic_lo", 64'(result_lo), 64'd15);
        check("basic_hi", 64'(result_hi), 64'd0);
        check("basic_model", m_res, 64'd15);
        adv();

        // Wide operands.
        mul_wait(32'hFFFF_FFFF, 32'd2, lat);
        check("wide_latency", 64'(lat), 64'd33);
        check("wide_lo", 64'(result_lo), 64'hFFFF_FFFE);
`ifdef MUL_SIGNED_EN
        check("wide_hi", 64'(result_hi), 64'hFFFF_FFFF);
        check("wide_model", m_res, 64'hFFFF_FFFF_FFFF_FFFE);
`else
        check("wide_hi", 64'(result_hi), 64'h0000_0001);
        check("wide_model", m_res, 64'h0000_0001_FFFF_FFFE);
`endif
        adv();

        // Non-mul request is ignored.
        start = 1'b1; ctrl = 4'b0110; src1 = 32'd9; src2 = 32'd9;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("nonmul_stall", 64'(stall), 64'd0);
            check("nonmul_busy",  64'(busy),  64'd0);
            check("nonmul_lo",    64'(result_lo), 64'hFFFF_FFFE);
            adv();
        end
        start = 1'b0;
        sample();
        adv();

        // Start ignored in RUN: 7*7 offered in cycle 10 of a 3*5 run.
        start = 1'b1; ctrl = MUL; src1 = 32'd3; src2 = 32'd5;
        sample();
        adv();
        start = 1'b0;
        c = 1;
        while (c < 10) begin
            sample();
            adv();
            c++;
        end
        start = 1'b1; ctrl = MUL; src1 = 32'd7; src2 = 32'd7;
        sample();
        check("ignore_stall", 64'(stall), 64'd1);
        check("ignore_busy",  64'(busy),  64'd1);
        adv();
        start = 1'b0;
        c = 11;
        sample();
        while (!done && c < 100) begin
            adv();
            c++;
            sample();
        end
        check("ignore_latency", 64'(c), 64'd33);
        check("ignore_lo", 64'(result_lo), 64'd15);
        adv();
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            sample();
            if (done) extra++;
            adv();
        end
        check("ignore_no_second_done", 64'(extra), 64'd0);

        // Reset in cycle 12 of a run.
        start = 1'b1; ctrl = MUL; src1 = 32'd3; src2 = 32'd5;
        sample();
        adv();
        start = 1'b0;
        c = 1;
        while (c < 12) begin
            sample();
            adv();
            c++;
        end
        rst = 1'b1;
        sample();
        check("midrst_lo",    64'(result_lo), 64'd0);
        check("midrst_hi",    64'(result_hi), 64'd0);
        check("midrst_done",  64'(done),  64'd0);
        check("midrst_busy",  64'(busy),  64'd0);
        check("midrst_stall", 64'(stall), 64'd0);
        adv();
        rst = 1'b0;
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            sample();
            if (done) extra++;
            adv();
        end
        check("midrst_no_done", 64'(extra), 64'd0);

        // Back-to-back: 6*7 held in the DONE cycle of 3*5.
        start = 1'b1; ctrl = MUL; src1 = 32'd3; src2 = 32'd5;
        sample();
        adv();
        start = 1'b0;
        c = 1;
        while (c < 33) begin
            sample();
            adv();
            c++;
        end
        start = 1'b1; ctrl = MUL; src1 = 32'd6; src2 = 32'd7;
        sample();
        check("b2b_first_done",  64'(done),  64'd1);
        check("b2b_first_lo",    64'(result_lo), 64'd15);
        check("b2b_second_stall", 64'(stall), 64'd1);
        adv();
        start = 1'b0;
        c = 1;
        sample();
        check("b2b_busy", 64'(busy), 64'd1);
        while (!done && c < 100) begin
            adv();
            c++;
            sample();
        end
        check("b2b_latency", 64'(c), 64'd33);
        check("b2b_second_lo", 64'(result_lo), 64'd42);
        check("b2b_model", m_res, 64'd42);
        adv();
        sample();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
